cart_sav_engine: RTL
====================

Name: cart_sav_engine

Overview:
Battery-backed cart RAM save/load engine. It drives port B of the cart RAM dual-port memories and the hps_io SD block interface. Load copies a mounted .sav image into cart RAM; save copies cart RAM back out in 512-byte blocks. It sits beside the cart mapper and is clocked on clk_sys, the same clock as cart RAM port B.

Parameters:
- ADDR_W, 17, cart RAM byte address width (128 KB max).
- LBA_W, 8, block counter width (256 blocks max).

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- cart_mbc2  in  1  cart uses MBC2 internal RAM (512 bytes).
- cart_ram_size  in  8  header RAM size code.
- sav_supported  in  1  battery cart with RAM; gates all transfers.
- img_mounted  in  1  one-cycle pulse on image mount/unmount.
- img_readonly  in  1  image is write-protected.
- img_size  in  64  image size in bytes; 0 means unmounted.
- bk_load  in  1  level; rising edge requests load.
- bk_save  in  1  level; rising edge requests save.
- osd_active  in  1  OSD open; used only with the optional feature.
- cram_wr  in  1  CPU write strobe into cart RAM; sets the dirty flag.
- sd_lba  out  32  block number, {24'd0, lba}.
- sd_rd  out  1  block read request.
- sd_wr  out  1  block write request.
- sd_ack  in  1  hps block transfer in progress.
- sd_buff_addr  in  9  byte index within the block.
- sd_buff_dout  in  8  load data from hps.
- sd_buff_wr  in  1  load data strobe.
- sd_buff_din  out  8  save data to hps.
- bram_addr  out  ADDR_W  cart RAM port B address.
- bram_wr  out  1  port B write enable.
- bram_di  out  8  port B write data.
- bram_do  in  8  port B read data; 1-cycle latency.
- bk_busy  out  1  transfer in progress.
- sav_dirty  out  1  cart RAM modified since last load/save.

Behaviour:
- Reset values: state IDLE, lba 0, sd_rd/sd_wr/bram_wr 0, bk_busy 0, sav_dirty 0, mounted 0.
- Block count N:
  - MBC2: 1.
  - ram_size 1: 4. ram_size 2: 16. ram_size 3: 64. ram_size 4 or more: 256.
  - ram_size 0 and not MBC2: 0, so no transfer starts.
  - Last block index is N-1.
- Mounted flag:
  - On an img_mounted pulse, mounted <= (img_size != 0).
  - If mounted becomes 1, sav_supported=1 and N>0, a load is requested automatically.
- Manual requests:
  - Rising edge of bk_load: load request, valid only if mounted, sav_supported and N>0.
  - Rising edge of bk_save: save request, additionally requires ~img_readonly.
  - Requests are honoured only in IDLE; requests while busy are dropped, not queued.
  - Load and save in the same cycle: load wins.
- FSM states: IDLE, REQ, XFER, NEXT.
  - IDLE to REQ on a valid request. On entry: lba <= 0, op latched, bk_busy <= 1; a save clears sav_dirty on entry.
  - REQ: assert sd_rd (load) or sd_wr (save). When sd_ack=1, deassert the request and go to XFER.
  - XFER: wait for sd_ack=0, then go to NEXT.
  - NEXT: if lba == N-1, go to IDLE with bk_busy <= 0. Otherwise lba++ and go to REQ.
- Address: bram_addr = {lba, sd_buff_addr} truncated to ADDR_W.
- Load data path: bram_wr = sd_buff_wr & load op & state XFER or REQ-with-ack, combinational. bram_di = sd_buff_dout. Same cycle as the strobe.
- Save data path: bram_addr follows sd_buff_addr combinationally. sd_buff_din = bram_do, valid 1 cycle after sd_buff_addr changes. hps samples at least 1 cycle later.
- A CPU cram_wr during a load or save still sets sav_dirty in the same cycle as the write; a save clears it only on entry. No arbitration is needed because port A is independent.
- Reset mid-transfer: immediate return to IDLE with sd_rd/sd_wr low. A partial image is not rolled back.
- Unmount pulse during busy: mounted <= 0; the current transfer completes.

Optional Feature:
- CART_SAV_AUTOSAVE_EN defined: a rising edge of osd_active with sav_dirty=1 acts as a save request, under the same gating as bk_save.
- Not defined: osd_active is ignored and only bk_save triggers a save.

Decomposition:
- Package cart_sav_pkg:
  - sav_state_t enum (IDLE, REQ, XFER, NEXT).
  - sav_op_t enum (OP_LOAD, OP_SAVE).
  - Function blk_count(mbc2, ram_size) returning the 9-bit N.
- Sub-module sav_edge_det: one-cycle rising-edge detector. Instantiated for bk_load, bk_save and osd_active.

Test Plan:
- Load: ram_size=2, sav_supported=1, img_mounted pulse with img_size=8192. Required: 16 sd_rd handshakes on lba 0..15; bram bytes equal the image bytes; bk_busy drops after lba 15.
- Save: ram_size=3, mounted, not readonly, bk_save edge. Required: 64 sd_wr blocks; sd_buff_din equals the RAM byte at {lba, addr} one cycle after addr; sav_dirty=0 after start.
- Gating: img_readonly=1 with bk_save gives no sd_wr. ram_size=0 with non-MBC2 gives no transfer. img_size=0 gives mounted=0 and no load.
- Contention: bk_load and bk_save rising in the same cycle runs a load only. bk_save edge during a load is dropped (no sd_wr afterwards).
- Reset mid-operation: reset asserted at lba=5 in REQ. Required: sd_rd=0 and bk_busy=0 asynchronously; IDLE after release.
- CART_SAV_AUTOSAVE_EN: cram_wr pulse then osd_active rise gives a full save. With sav_dirty=0, osd_active gives no save. With the macro undefined, osd_active gives no save.

Source files
------------

// File: rtl/cart_sav_pkg.sv
// Shared types and block-count decode for the cart RAM save/load engine.
package cart_sav_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} sav_state_t;
  typedef enum logic {OP_LOAD, OP_SAVE} sav_op_t;

  // Number of 512-byte blocks backing the cart RAM; 0 means nothing to save.
  function automatic logic [8:0] blk_count(input logic mbc2, input logic [7:0] ram_size);
    logic [8:0] n;
    if (mbc2) n = 9'd1;
    else begin
      case (ram_size)
        8'd0:    n = 9'd0;
        8'd1:    n = 9'd4;
        8'd2:    n = 9'd16;
        8'd3:    n = 9'd64;
        default: n = 9'd256;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sav_edge_det.sv
// One-cycle rising-edge detector on a level input.
module sav_edge_det (
  input  logic clk_sys,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/cart_sav_engine.sv
// Cart RAM .sav load/save engine between cart RAM port B and hps_io SD blocks.
// Optional: define CART_SAV_AUTOSAVE_EN to save on OSD open when RAM is dirty.
module cart_sav_engine
  import cart_sav_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int LBA_W  = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cart_mbc2,
  input  logic [7:0]        cart_ram_size,
  input  logic              sav_supported,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              bk_load,
  input  logic              bk_save,
  input  logic              osd_active,
  input  logic              cram_wr,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_wr,
  output logic [7:0]        bram_di,
  input  logic [7:0]        bram_do,
  output logic              bk_busy,
  output logic              sav_dirty
);

  sav_state_t       state, state_n;
  sav_op_t          op;
  logic [LBA_W-1:0] lba;
  logic [LBA_W:0]   n_ext;
  logic [LBA_W+8:0] full_addr;
  logic [8:0]       n_blk;
  logic [2:0]       lvl, rise;
  logic             mounted, mount_ld;
  logic             gate, ld_req, sv_req, save_trig, start, last;

  // bit 0: bk_load, bit 1: bk_save, bit 2: osd_active
  assign lvl = {osd_active, bk_save, bk_load};

  for (genvar i = 0; i < 3; i++) begin : g_edge
    sav_edge_det u_edge (
      .clk_sys (clk_sys),
      .reset   (reset),
      .level   (lvl[i]),
      .rise    (rise[i])
    );
  end

`ifdef CART_SAV_AUTOSAVE_EN
  assign save_trig = rise[1] | (rise[2] & sav_dirty);
`else
  logic unused_osd;
  assign unused_osd = rise[2];
  assign save_trig  = rise[1];
`endif

  assign n_blk  = blk_count(cart_mbc2, cart_ram_size);
  assign n_ext  = (LBA_W+1)'(n_blk);
  assign last   = ({1'b0, lba} == n_ext - (LBA_W+1)'(1));
  assign gate   = mounted & sav_supported & (n_blk != 9'd0);
  assign ld_req = (rise[0] | mount_ld) & gate;
  assign sv_req = save_trig & gate & ~img_readonly;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: if (ld_req || sv_req) begin
        state_n = REQ;
        start   = 1'b1;
      end
      REQ:  if (sd_ack)  state_n = XFER;
      XFER: if (!sd_ack) state_n = NEXT;
      NEXT: state_n = last ? IDLE : REQ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lba       <= '0;
      op        <= OP_LOAD;
      bk_busy   <= 1'b0;
      sav_dirty <= 1'b0;
      mounted   <= 1'b0;
      mount_ld  <= 1'b0;
    end else begin
      // auto-load fires the cycle after a non-empty mount, once mounted is visible
      mount_ld <= img_mounted & (img_size != 64'd0);
      if (img_mounted) mounted <= (img_size != 64'd0);
      if (start) begin
        lba     <= '0;
        op      <= ld_req ? OP_LOAD : OP_SAVE;
        bk_busy <= 1'b1;
      end else if (state == NEXT) begin
        if (last) bk_busy <= 1'b0;
        else      lba     <= lba + LBA_W'(1);
      end
      // a CPU write racing a save start keeps the flag set: that byte may be missed
      if (cram_wr)                sav_dirty <= 1'b1;
      else if (start && !ld_req)  sav_dirty <= 1'b0;
    end
  end

  assign sd_lba      = 32'(lba);
  assign sd_rd       = (state == REQ) && (op == OP_LOAD);
  assign sd_wr       = (state == REQ) && (op == OP_SAVE);
  assign full_addr   = {lba, sd_buff_addr};
  assign bram_addr   = full_addr[ADDR_W-1:0];
  assign bram_di     = sd_buff_dout;
  assign sd_buff_din = bram_do;
  assign bram_wr     = sd_buff_wr && (op == OP_LOAD) &&
                       ((state == XFER) || ((state == REQ) && sd_ack));

endmodule
